// File: rtl/alu_opc_pkg.sv
// alu_opc_pkg
// Shared definitions for the ALU operand collector: FSM state encoding,
// the single-operand command codes of both command sets, and a helper
// that reports which operands a command consumes.
package alu_opc_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      WAIT_A = 2'd1,
      WAIT_B = 2'd2
   } state_t;

   // Arithmetic set (MODE=1), single-operand commands
   localparam logic [7:0] ARITH_INC_A = 8'd4;
   localparam logic [7:0] ARITH_DEC_A = 8'd5;
   localparam logic [7:0] ARITH_INC_B = 8'd6;
   localparam logic [7:0] ARITH_DEC_B = 8'd7;

   // Logical set (MODE=0), single-operand commands
   localparam logic [7:0] LOGIC_NOT_A = 8'd6;
   localparam logic [7:0] LOGIC_NOT_B = 8'd7;
   localparam logic [7:0] LOGIC_SHR_A = 8'd8;
   localparam logic [7:0] LOGIC_SHL_A = 8'd9;
   localparam logic [7:0] LOGIC_SHR_B = 8'd10;
   localparam logic [7:0] LOGIC_SHL_B = 8'd11;

   // Returns {need_b, need_a}. Anything not listed is a two-operand command.
   function automatic logic [1:0] op_need(input logic mode, input logic [7:0] cmd);
      logic [1:0] need;
      need = 2'b11;
      if (mode) begin
         case (cmd)
            ARITH_INC_A, ARITH_DEC_A: need = 2'b01;
            ARITH_INC_B, ARITH_DEC_B: need = 2'b10;
            default:                  need = 2'b11;
         endcase
      end else begin
         case (cmd)
            LOGIC_NOT_A, LOGIC_SHR_A, LOGIC_SHL_A: need = 2'b01;
            LOGIC_NOT_B, LOGIC_SHR_B, LOGIC_SHL_B: need = 2'b10;
            default:                               need = 2'b11;
         endcase
      end
      return need;
   endfunction

endpackage

// File: rtl/alu_opc_timer.sv
// alu_opc_timer
// Counts clock-enabled wait cycles for the operand collector.
// Ports: clk, rst (async, active-high), clear (synchronous, wins over
// enable), enable (count this cycle), expired (the current wait cycle is
// the last one in which the missing operand may still arrive).
module alu_opc_timer #(
   parameter int TIMEOUT = 16
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic enable,
   output logic expired
);

   localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT);

   logic [CW-1:0] cnt;

   // cnt holds (wait cycle number - 1), so it reaches TIMEOUT-1 on the
   // final accepted cycle and never needs to count past it.
   assign expired = (cnt == CW'(TIMEOUT - 1));

   always_ff @(posedge clk or posedge rst) begin
      if (rst)
         cnt <= '0;
      else if (clear)
         cnt <= '0;
      else if (enable && !expired)
         cnt <= cnt + 1'b1;
   end

endmodule

// File: rtl/alu_operand_collector.sv
// alu_operand_collector
// Gathers OPA/OPB (which may arrive on different cycles) into one complete
// operation for the ALU core and presents it as a single-cycle OP_VALID pulse.
// Ports:
//   CLK, RST (async, active-high), CE (clock enable, freezes all state)
//   MODE, CMD, INP_VALID[1:0] (bit0 OPA, bit1 OPB), OPA, OPB, CIN
//   OP_VALID, OP_MODE, OP_CMD, OP_A, OP_B, OP_CIN : collected operation
//   TIMEOUT_ERR : pulse when a missing operand never arrived
//   BUSY        : waiting for a missing operand
// Build option: define ALU_OPC_TIMEOUT_EN to abandon a wait after TIMEOUT
// enabled cycles; otherwise a wait lasts until the operand arrives or reset.
module alu_operand_collector
   import alu_opc_pkg::*;
#(
   parameter int WIDTH     = 8,
   parameter int CMD_WIDTH = 4,
   parameter int TIMEOUT   = 16
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 CE,
   input  logic                 MODE,
   input  logic [CMD_WIDTH-1:0] CMD,
   input  logic [1:0]           INP_VALID,
   input  logic [WIDTH-1:0]     OPA,
   input  logic [WIDTH-1:0]     OPB,
   input  logic                 CIN,
   output logic                 OP_VALID,
   output logic                 OP_MODE,
   output logic [CMD_WIDTH-1:0] OP_CMD,
   output logic [WIDTH-1:0]     OP_A,
   output logic [WIDTH-1:0]     OP_B,
   output logic                 OP_CIN,
   output logic                 TIMEOUT_ERR,
   output logic                 BUSY
);

   state_t               state;
   logic                 lat_mode;
   logic [CMD_WIDTH-1:0] lat_cmd;
   logic [WIDTH-1:0]     lat_a;
   logic [WIDTH-1:0]     lat_b;
   logic                 lat_cin;
   logic [1:0]           need;
   logic                 expired;

   assign need = op_need(MODE, 8'(CMD));
   assign BUSY = (state != IDLE);

`ifdef ALU_OPC_TIMEOUT_EN
   alu_opc_timer #(.TIMEOUT(TIMEOUT)) u_timer (
      .clk     (CLK),
      .rst     (RST),
      .clear   (CE && state == IDLE),
      .enable  (CE && state != IDLE),
      .expired (expired)
   );
`else
   assign expired = 1'b0;
`endif

   // Pulses are rebuilt every edge so they last exactly one cycle and are
   // never produced on a CE=0 edge. The OP_* data registers only load on
   // completion, so they hold the last operation between pulses.
   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state       <= IDLE;
         lat_mode    <= 1'b0;
         lat_cmd     <= '0;
         lat_a       <= '0;
         lat_b       <= '0;
         lat_cin     <= 1'b0;
         OP_VALID    <= 1'b0;
         OP_MODE     <= 1'b0;
         OP_CMD      <= '0;
         OP_A        <= '0;
         OP_B        <= '0;
         OP_CIN      <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
      end else begin
         OP_VALID    <= 1'b0;
         TIMEOUT_ERR <= 1'b0;
         if (CE) begin
            case (state)
               IDLE: begin
                  if ((INP_VALID & need) == need) begin
                     OP_VALID <= 1'b1;
                     OP_MODE  <= MODE;
                     OP_CMD   <= CMD;
                     OP_A     <= OPA;
                     OP_B     <= OPB;
                     OP_CIN   <= CIN;
                  end else if (need == 2'b11 && INP_VALID != 2'b00) begin
                     lat_mode <= MODE;
                     lat_cmd  <= CMD;
                     lat_a    <= OPA;
                     lat_b    <= OPB;
                     lat_cin  <= CIN;
                     state    <= INP_VALID[0] ? WAIT_B : WAIT_A;
                  end
               end
               WAIT_A, WAIT_B: begin
                  // A fresh copy of the already-held operand, if flagged
                  // valid alongside the missing one, replaces the latched one.
                  if ((state == WAIT_A) ? INP_VALID[0] : INP_VALID[1]) begin
                     OP_VALID <= 1'b1;
                     OP_MODE  <= lat_mode;
                     OP_CMD   <= lat_cmd;
                     OP_A     <= INP_VALID[0] ? OPA : lat_a;
                     OP_B     <= INP_VALID[1] ? OPB : lat_b;
                     OP_CIN   <= lat_cin;
                     state    <= IDLE;
                  end else if (expired) begin
                     TIMEOUT_ERR <= 1'b1;
                     state       <= IDLE;
                  end
               end
               default: state <= IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_alu_operand_collector.sv
module tb_alu_operand_collector;

   localparam int W   = 8;
   localparam int CW  = 4;
   localparam int TMO = 16;
`ifdef ALU_OPC_TIMEOUT_EN
   localparam bit TMO_ON = 1'b1;
`else
   localparam bit TMO_ON = 1'b0;
`endif

   logic          CLK = 1'b0;
   logic          RST, CE, MODE, CIN;
   logic [CW-1:0] CMD;
   logic [1:0]    INP_VALID;
   logic [W-1:0]  OPA, OPB;
   logic          OP_VALID, OP_MODE, OP_CIN, TIMEOUT_ERR, BUSY;
   logic [CW-1:0] OP_CMD;
   logic [W-1:0]  OP_A, OP_B;

   int n_chk  = 0;
   int n_pass = 0;

   alu_operand_collector #(.WIDTH(W), .CMD_WIDTH(CW), .TIMEOUT(TMO)) dut (
      .CLK(CLK), .RST(RST), .CE(CE), .MODE(MODE), .CMD(CMD),
      .INP_VALID(INP_VALID), .OPA(OPA), .OPB(OPB), .CIN(CIN),
      .OP_VALID(OP_VALID), .OP_MODE(OP_MODE), .OP_CMD(OP_CMD),
      .OP_A(OP_A), .OP_B(OP_B), .OP_CIN(OP_CIN),
      .TIMEOUT_ERR(TIMEOUT_ERR), .BUSY(BUSY)
   );

   always #5 CLK = ~CLK;

   // Reference model: a pending-transaction record plus expected outputs.
   bit            pend;
   bit            miss_a;
   int            age;
   bit            p_mode, p_cin;
   logic [CW-1:0] p_cmd;
   logic [W-1:0]  p_a, p_b;
   bit            e_valid, e_err, e_mode, e_cin;
   logic [CW-1:0] e_cmd;
   logic [W-1:0]  e_a, e_b;

   // Which operands a command consumes, straight from the command table.
   function automatic bit [1:0] needs(input bit mode, input int cmd);
      if (mode) begin
         if (cmd == 4 || cmd == 5) return 2'b01;
         if (cmd == 6 || cmd == 7) return 2'b10;
      end else begin
         if (cmd == 6 || cmd == 8 || cmd == 9)   return 2'b01;
         if (cmd == 7 || cmd == 10 || cmd == 11) return 2'b10;
      end
      return 2'b11;
   endfunction

   task automatic model_reset();
      pend = 0; age = 0;
      e_valid = 0; e_err = 0; e_mode = 0; e_cin = 0; e_cmd = '0; e_a = '0; e_b = '0;
   endtask

   task automatic model_step(input bit ce, input bit mode, input logic [CW-1:0] cmd,
                             input logic [1:0] iv, input logic [W-1:0] a,
                             input logic [W-1:0] b, input bit cin);
      bit [1:0] n;
      e_valid = 0; e_err = 0;
      if (!ce) return;
      if (!pend) begin
         n = needs(mode, int'(cmd));
         if ((iv & n) == n) begin
            e_valid = 1; e_mode = mode; e_cmd = cmd; e_a = a; e_b = b; e_cin = cin;
         end else if (n == 2'b11 && iv != 0) begin
            pend = 1; miss_a = (iv == 2'b10); age = 0;
            p_mode = mode; p_cmd = cmd; p_a = a; p_b = b; p_cin = cin;
         end
      end else begin
         age++;
         if (miss_a ? iv[0] : iv[1]) begin
            e_valid = 1; e_mode = p_mode; e_cmd = p_cmd; e_cin = p_cin;
            e_a = iv[0] ? a : p_a;
            e_b = iv[1] ? b : p_b;
            pend = 0;
         end else if (TMO_ON && age == TMO) begin
            e_err = 1; pend = 0;
         end
      end
   endtask

   // Apply one cycle of inputs, advance the model, sample 1 time unit after the edge.
   task automatic drive_cycle(input bit ce, input bit mode, input logic [CW-1:0] cmd,
                              input logic [1:0] iv, input logic [W-1:0] a,
                              input logic [W-1:0] b, input bit cin);
      CE = ce; MODE = mode; CMD = cmd; INP_VALID = iv; OPA = a; OPB = b; CIN = cin;
      model_step(ce, mode, cmd, iv, a, b, cin);
      @(posedge CLK);
      #1;
   endtask

   task automatic idle_cycles(input int n, input bit ce);
      for (int i = 0; i < n; i++) drive_cycle(ce, 1'b0, 4'd0, 2'b00, 8'h00, 8'h00, 1'b0);
   endtask

   task automatic do_reset();
      RST = 1; CE = 0; MODE = 0; CMD = '0; INP_VALID = '0; OPA = '0; OPB = '0; CIN = 0;
      model_reset();
      repeat (2) @(posedge CLK);
      @(negedge CLK);
      RST = 0;
   endtask

   task automatic test_reset();
      do_reset();
      n_chk++; if ({OP_VALID, TIMEOUT_ERR, BUSY} !== 3'b000) $display("FAIL reset_flags: got %b exp 000", {OP_VALID, TIMEOUT_ERR, BUSY}); else n_pass++;
      n_chk++; if ({OP_MODE, OP_CMD, OP_A, OP_B, OP_CIN} !== '0) $display("FAIL reset_data: got %h exp 0", {OP_MODE, OP_CMD, OP_A, OP_B, OP_CIN}); else n_pass++;
   endtask

   task automatic test_both_operands();
      drive_cycle(1, 1, 4'd0, 2'b11, 8'h12, 8'h34, 0);
      n_chk++; if (OP_VALID !== 1'b1) $display("FAIL both_valid: got %b exp 1", OP_VALID); else n_pass++;
      n_chk++; if ({OP_A, OP_B} !== 16'h1234) $display("FAIL both_data: got %h exp 1234", {OP_A, OP_B}); else n_pass++;
      n_chk++; if (BUSY !== 1'b0) $display("FAIL both_busy: got %b exp 0", BUSY); else n_pass++;
      idle_cycles(1, 1);
      n_chk++; if ({OP_VALID, OP_A, OP_B} !== 17'h01234) $display("FAIL hold_data: got %h exp 01234", {OP_VALID, OP_A, OP_B}); else n_pass++;
   endtask

   task automatic test_split();
      drive_cycle(1, 1, 4'd0, 2'b01, 8'h05, 8'hEE, 1);
      n_chk++; if ({BUSY, OP_VALID} !== 2'b10) $display("FAIL split_wait: got %b exp 10", {BUSY, OP_VALID}); else n_pass++;
      idle_cycles(2, 1);
      // new CMD/MODE during the wait must be ignored
      drive_cycle(1, 0, 4'd9, 2'b10, 8'hAA, 8'h07, 0);
      n_chk++; if (OP_VALID !== 1'b1) $display("FAIL split_valid: got %b exp 1", OP_VALID); else n_pass++;
      n_chk++; if ({OP_A, OP_B} !== 16'h0507) $display("FAIL split_data: got %h exp 0507", {OP_A, OP_B}); else n_pass++;
      n_chk++; if ({OP_MODE, OP_CMD, OP_CIN, BUSY} !== 7'b1_0000_1_0) $display("FAIL split_fields: got %b exp 1000010", {OP_MODE, OP_CMD, OP_CIN, BUSY}); else n_pass++;
   endtask

   task automatic test_single_operand();
      drive_cycle(1, 1, 4'd4, 2'b01, 8'hFF, 8'h00, 0);
      n_chk++; if ({OP_VALID, BUSY, OP_A} !== 10'b10_1111_1111) $display("FAIL one_a: got %b exp 1011111111", {OP_VALID, BUSY, OP_A}); else n_pass++;
      drive_cycle(1, 0, 4'd10, 2'b10, 8'h00, 8'h3C, 0);
      n_chk++; if ({OP_VALID, BUSY, OP_B} !== 10'b10_0011_1100) $display("FAIL one_b: got %b exp 1000111100", {OP_VALID, BUSY, OP_B}); else n_pass++;
      drive_cycle(1, 1, 4'd4, 2'b10, 8'h11, 8'h22, 0);
      n_chk++; if ({OP_VALID, BUSY} !== 2'b00) $display("FAIL one_wrong_operand: got %b exp 00", {OP_VALID, BUSY}); else n_pass++;
   endtask

   task automatic test_timeout();
      bit bad = 0;
      drive_cycle(1, 0, 4'd0, 2'b10, 8'h00, 8'hAB, 0);
      for (int k = 1; k < TMO; k++) begin
         drive_cycle(1, 0, 4'd0, 2'b00, 8'h00, 8'h00, 0);
         if ({BUSY, OP_VALID, TIMEOUT_ERR} !== 3'b100) bad = 1;
      end
      n_chk++; if (bad) $display("FAIL tmo_waiting: got early exit exp busy"); else n_pass++;
      drive_cycle(1, 0, 4'd0, 2'b00, 8'h00, 8'h00, 0);
      if (TMO_ON) begin
         n_chk++; if ({TIMEOUT_ERR, OP_VALID, BUSY} !== 3'b100) $display("FAIL tmo_err: got %b exp 100", {TIMEOUT_ERR, OP_VALID, BUSY}); else n_pass++;
         idle_cycles(1, 1);
         n_chk++; if ({TIMEOUT_ERR, BUSY} !== 2'b00) $display("FAIL tmo_after: got %b exp 00", {TIMEOUT_ERR, BUSY}); else n_pass++;
      end else begin
         n_chk++; if ({TIMEOUT_ERR, BUSY} !== 2'b01) $display("FAIL notmo_wait: got %b exp 01", {TIMEOUT_ERR, BUSY}); else n_pass++;
         drive_cycle(1, 0, 4'd0, 2'b01, 8'h5A, 8'h00, 0);
         n_chk++; if ({OP_VALID, OP_A, OP_B} !== 17'h15AAB) $display("FAIL notmo_done: got %h exp 15aab", {OP_VALID, OP_A, OP_B}); else n_pass++;
      end
   endtask

   task automatic test_ce_freeze();
      bit saw_err = 0;
      drive_cycle(1, 1, 4'd1, 2'b01, 8'h33, 8'h00, 1);
      for (int i = 0; i < 10; i++) begin drive_cycle(1, 1, 4'd1, 2'b00, 8'h0, 8'h0, 0); saw_err |= TIMEOUT_ERR; end
      // operands offered while CE=0 must be ignored
      for (int i = 0; i < 20; i++) begin drive_cycle(0, 1, 4'd1, 2'b10, 8'h0, 8'h99, 0); saw_err |= TIMEOUT_ERR | OP_VALID; end
      n_chk++; if ({BUSY, OP_VALID} !== 2'b10) $display("FAIL ce_frozen: got %b exp 10", {BUSY, OP_VALID}); else n_pass++;
      for (int i = 0; i < 5; i++) begin drive_cycle(1, 1, 4'd1, 2'b00, 8'h0, 8'h0, 0); saw_err |= TIMEOUT_ERR; end
      // 16th enabled wait cycle: last one that may still accept the operand
      drive_cycle(1, 1, 4'd1, 2'b10, 8'h00, 8'h44, 0);
      n_chk++; if (saw_err) $display("FAIL ce_no_err: got pulse exp none"); else n_pass++;
      n_chk++; if ({OP_VALID, TIMEOUT_ERR, OP_A, OP_B} !== 18'b10_0011_0011_0100_0100) $display("FAIL ce_done: got %b exp 100011001101000100", {OP_VALID, TIMEOUT_ERR, OP_A, OP_B}); else n_pass++;
   endtask

   task automatic test_reset_mid_wait();
      drive_cycle(1, 1, 4'd0, 2'b01, 8'h21, 8'h00, 0);
      #2 RST = 1;
      #1;
      n_chk++; if ({BUSY, OP_A} !== 9'h000) $display("FAIL rst_mid: got %h exp 000", {BUSY, OP_A}); else n_pass++;
      model_reset();
      @(negedge CLK);
      RST = 0;
      drive_cycle(1, 1, 4'd0, 2'b10, 8'h00, 8'h77, 0);
      n_chk++; if (OP_VALID !== 1'b0) $display("FAIL rst_no_complete: got %b exp 0", OP_VALID); else n_pass++;
   endtask

   task automatic test_random();
      bit ce, mode, cin;
      logic [CW-1:0] cmd;
      logic [1:0] iv;
      logic [W-1:0] a, b;
      do_reset();
      for (int i = 0; i < 600; i++) begin
         ce   = ($urandom_range(0, 7) != 0);
         mode = 1'($urandom_range(0, 1));
         cmd  = CW'($urandom_range(0, 15));
         iv   = ($urandom_range(0, 3) == 0) ? 2'($urandom_range(0, 3)) : 2'b00;
         a    = W'($urandom); b = W'($urandom); cin = 1'($urandom_range(0, 1));
         drive_cycle(ce, mode, cmd, iv, a, b, cin);
         n_chk++; if (OP_VALID !== e_valid) $display("FAIL rnd_valid@%0d: got %b exp %b", i, OP_VALID, e_valid); else n_pass++;
         n_chk++; if (TIMEOUT_ERR !== e_err) $display("FAIL rnd_err@%0d: got %b exp %b", i, TIMEOUT_ERR, e_err); else n_pass++;
         n_chk++; if (BUSY !== pend) $display("FAIL rnd_busy@%0d: got %b exp %b", i, BUSY, pend); else n_pass++;
         n_chk++; if ({OP_MODE, OP_CMD, OP_CIN} !== {e_mode, e_cmd, e_cin}) $display("FAIL rnd_fields@%0d: got %h exp %h", i, {OP_MODE, OP_CMD, OP_CIN}, {e_mode, e_cmd, e_cin}); else n_pass++;
         n_chk++; if ({OP_A, OP_B} !== {e_a, e_b}) $display("FAIL rnd_data@%0d: got %h exp %h", i, {OP_A, OP_B}, {e_a, e_b}); else n_pass++;
      end
   endtask

   initial begin
      test_reset();
      test_both_operands();
      test_split();
      test_single_operand();
      test_timeout();
      test_ce_freeze();
      test_reset_mid_wait();
      test_random();
      $display("%0d/%0d checks passed", n_pass, n_chk);
      $finish;
   end

endmodule
